fir_coef_loader: RTL and testbench
==================================

# fir_coef_loader

Run-time coefficient loader and sequencer for the transposed-form FIR filter. It accepts a new coefficient set over a valid/ready stream into a shadow bank while the filter keeps running on the active bank. It then swaps banks atomically, clears the filter pipeline and masks the filter output until the new impulse response has fully propagated. It sits between the control/config path and the FIR datapath, driving the filter's weights, enable and clear inputs.

## Interface
- DATA_WIDTH, 24, coefficient width (signed), matches filter DATA_WIDTH
- FIR_DEPTH, 16, number of taps; must be ≥ 2
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_load_start  in  1  pulse: begin loading a new coefficient set
- i_load_abort  in  1  pulse: discard a load in progress
- iv_coef  in  DATA_WIDTH  coefficient beat, signed
- i_coef_valid  in  1  iv_coef valid
- o_coef_ready  out  1  loader accepts a beat
- i_sample_valid  in  1  the filter's input-sample valid (observed only)
- ov_weights  out  FIR_DEPTH*DATA_WIDTH  active bank; tap i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- o_fir_en  out  1  filter enable
- o_fir_clr  out  1  filter pipeline clear; top level ORs it with i_rst into the filter reset
- o_out_gate  out  1  1 = filter output valid may be passed downstream
- o_drop  out  1  sample presented while filter disabled (lost)
- o_busy  out  1  state ≠ IDLE
- o_done  out  1  one-cycle pulse: new set active and settled

## Operation
- FSM states: IDLE, LOAD, SWAP, CLEAR, SETTLE. Outputs are a Moore decode of the state plus registered banks.
- IDLE: o_coef_ready=0. On i_load_start: idx←0, go to LOAD.
- LOAD: o_coef_ready=1. On each beat (valid&ready): shadow[idx]←iv_coef, idx←idx+1. First beat = tap 0. The beat with idx=FIR_DEPTH-1 moves to SWAP. The filter keeps running on the active bank throughout. i_load_abort moves to IDLE with the active bank untouched; abort wins over a same-cycle beat.
- SWAP (1 cycle): o_fir_en=0; active←shadow at end of cycle.
- CLEAR (1 cycle): o_fir_en=0, o_fir_clr=1.
- SETTLE: o_fir_en=1, o_out_gate=0. Count accepted samples (i_sample_valid) from 0; on count FIR_DEPTH-1 with i_sample_valid, go to IDLE and assert o_done that cycle. The counter needs ceil(log2(FIR_DEPTH)) bits.
- o_out_gate=1 in every state except SETTLE.
- o_drop = i_sample_valid & ~o_fir_en (combinational). It is high only in SWAP and CLEAR.
- i_load_start is ignored when state ≠ IDLE. i_load_abort is ignored outside LOAD.
- Coefficients are stored unmodified; there is no arithmetic on weights.

## Timing
- Reset values: state=IDLE, active and shadow banks all zero, idx=0, o_coef_ready=0, o_fir_en=1, o_fir_clr=0, o_out_gate=1, o_busy=0, o_done=0.
- Reset applied mid-operation returns to IDLE with both banks zeroed. Any partial load is lost.
- i_load_start sampled at cycle t: o_coef_ready=1 and o_busy=1 from t+1.
- Last beat accepted at t': SWAP at t'+1, new ov_weights visible at t'+2 (CLEAR), SETTLE from t'+3.
- o_fir_en is low for exactly 2 cycles per load. o_fir_clr is high for exactly 1 cycle.
- Minimum load-start to done is FIR_DEPTH + 2 + FIR_DEPTH cycles, with back-to-back beats and samples.
- The ready/valid handshake is stall-tolerant: gaps in i_coef_valid hold idx. No beat is accepted outside LOAD.
- o_done is a single pulse coincident with the transition to IDLE. o_busy falls the next cycle.
- A start in the same cycle as o_done is ignored, because state ≠ IDLE. It is accepted one cycle later.

## Test plan
- Reset, then a load of taps 1..16 back-to-back with continuous samples -> ov_weights tap i = i+1 at t'+2; o_fir_en low 2 cycles; o_fir_clr 1 cycle; o_out_gate low for 16 samples; o_done at the 16th; filter impulse response equals 1..16.
- Load with i_coef_valid toggling every other cycle -> 16 beats accepted in 31 cycles; idx holds through gaps; final bank correct.
- Abort after 7 beats -> state IDLE next cycle; ov_weights unchanged from the prior set; o_coef_ready=0; no o_fir_clr.
- i_sample_valid held high through SWAP and CLEAR -> o_drop high exactly 2 cycles; SETTLE counts only samples arriving after CLEAR.
- i_load_start while in LOAD or SETTLE -> ignored, no idx reset. Start on the o_done cycle -> ignored; start one cycle later -> accepted.
- i_rst asserted mid-SETTLE -> all outputs at reset values next cycle, ov_weights all zero.

Source files
------------

// File: rtl/fir_coef_loader.sv
// Run-time coefficient loader for the transposed-form FIR.
// Shadow-bank load over valid/ready, atomic bank swap, pipeline clear, then output masking.
module fir_coef_loader #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned FIR_DEPTH  = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_load_start,
  input  logic                            i_load_abort,
  input  logic [DATA_WIDTH-1:0]           iv_coef,
  input  logic                            i_coef_valid,
  output logic                            o_coef_ready,
  input  logic                            i_sample_valid,
  output logic [FIR_DEPTH*DATA_WIDTH-1:0] ov_weights,
  output logic                            o_fir_en,
  output logic                            o_fir_clr,
  output logic                            o_out_gate,
  output logic                            o_drop,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int unsigned IdxW = (FIR_DEPTH > 1) ? $clog2(FIR_DEPTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FIR_DEPTH - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StSwap, StClear, StSettle} state_e;

  state_e                          r_state;
  state_e                          w_state_next;
  logic [IdxW-1:0]                 r_idx;
  logic [IdxW-1:0]                 r_cnt;
  logic [FIR_DEPTH*DATA_WIDTH-1:0] r_shadow;
  logic [FIR_DEPTH*DATA_WIDTH-1:0] r_active;
  logic                            w_beat;

  always_comb begin
    w_state_next = r_state;
    w_beat       = 1'b0;
    o_coef_ready = 1'b0;
    o_fir_en     = 1'b1;
    o_fir_clr    = 1'b0;
    o_out_gate   = 1'b1;
    o_done       = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_load_start) w_state_next = StLoad;
      end
      StLoad: begin
        o_coef_ready = 1'b1;
        // Abort takes priority: a beat in the abort cycle is not stored.
        if (i_load_abort) begin
          w_state_next = StIdle;
        end else if (i_coef_valid) begin
          w_beat = 1'b1;
          if (r_idx == LastIdx) w_state_next = StSwap;
        end
      end
      StSwap: begin
        o_fir_en     = 1'b0;
        w_state_next = StClear;
      end
      StClear: begin
        o_fir_en     = 1'b0;
        o_fir_clr    = 1'b1;
        w_state_next = StSettle;
      end
      StSettle: begin
        o_out_gate = 1'b0;
        if (i_sample_valid && (r_cnt == LastIdx)) begin
          o_done       = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_drop     = i_sample_valid & ~o_fir_en;
  assign o_busy     = (r_state != StIdle);
  assign ov_weights = r_active;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && i_load_start) r_idx <= '0;
      if (w_beat) begin
        r_shadow[r_idx*DATA_WIDTH +: DATA_WIDTH] <= iv_coef;
        r_idx                                    <= r_idx + 1'b1;
      end
      if (r_state == StSwap) r_active <= r_shadow;
      // Settle counter starts from zero on the first post-clear sample.
      if (r_state == StClear) begin
        r_cnt <= '0;
      end else if (r_state == StSettle && i_sample_valid) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed self-checking bench for fir_coef_loader.
// Output bundle order in checks: {ready, fir_en, fir_clr, out_gate, drop, busy, done}.
module tb_fir_coef_loader;

  localparam int DW = 24;
  localparam int D  = 16;
  localparam int WW = DW * D;

  logic          r_clk = 1'b0;
  logic          r_rst;
  logic          r_start;
  logic          r_abort;
  logic [DW-1:0] r_coef;
  logic          r_cvalid;
  logic          r_svalid;

  logic          w_ready;
  logic [WW-1:0] w_weights;
  logic          w_en;
  logic          w_clr;
  logic          w_gate;
  logic          w_drop;
  logic          w_busy;
  logic          w_done;

  int n_checks = 0;
  int n_pass   = 0;

  fir_coef_loader #(
    .DATA_WIDTH (DW),
    .FIR_DEPTH  (D)
  ) u_dut (
    .i_clk          (r_clk),
    .i_rst          (r_rst),
    .i_load_start   (r_start),
    .i_load_abort   (r_abort),
    .iv_coef        (r_coef),
    .i_coef_valid   (r_cvalid),
    .o_coef_ready   (w_ready),
    .i_sample_valid (r_svalid),
    .ov_weights     (w_weights),
    .o_fir_en       (w_en),
    .o_fir_clr      (w_clr),
    .o_out_gate     (w_gate),
    .o_drop         (w_drop),
    .o_busy         (w_busy),
    .o_done         (w_done)
  );

  always #5 r_clk = ~r_clk;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic outs(input string tag, input logic [6:0] exp);
    check(tag, WW'({w_ready, w_en, w_clr, w_gate, w_drop, w_busy, w_done}), WW'(exp));
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  // Tap i = base + i.
  function automatic logic [WW-1:0] bank(input logic [DW-1:0] base);
    logic [WW-1:0] b;
    for (int i = 0; i < D; i++) b[i*DW +: DW] = base + DW'(i);
    return b;
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    r_rst = 1'b1; r_start = 1'b0; r_abort = 1'b0;
    r_coef = '0; r_cvalid = 1'b0; r_svalid = 1'b0;
    tick(); tick();
    outs("reset_outs", 7'b0101000);
    check("reset_w", w_weights, '0);

    // Load 1..16 back-to-back, samples continuous.
    r_rst = 1'b0; r_svalid = 1'b1; r_start = 1'b1;
    #1 outs("idle_start", 7'b0101000);
    tick();
    r_start = 1'b0;
    for (int i = 0; i < D; i++) begin
      r_cvalid = 1'b1; r_coef = DW'(i + 1);
      #1 outs("load1", 7'b1101010);
      tick();
    end
    r_cvalid = 1'b0;
    #1 outs("swap1", 7'b0001110);
    check("swap1_w", w_weights, '0);
    tick();
    outs("clear1", 7'b0011110);
    check("clear1_w", w_weights, bank(24'd1));
    tick();
    for (int k = 0; k < D; k++) begin
      r_start = (k == D - 1);
      #1 outs("settle1", (k == D - 1) ? 7'b0100011 : 7'b0100010);
      tick();
    end
    r_start = 1'b0;
    #1 outs("start_on_done_ignored", 7'b0101000);

    // Start one cycle after done is accepted; stalled load with a start in LOAD.
    r_start = 1'b1;
    tick();
    r_start = 1'b0; r_svalid = 1'b0;
    #1 outs("load2_entry", 7'b1101010);
    for (int c = 0; c < 2 * D - 1; c++) begin
      if (c % 2 == 0) begin
        r_cvalid = 1'b1; r_coef = 24'hF00000 + DW'(c / 2); r_start = 1'b0;
      end else begin
        r_cvalid = 1'b0; r_coef = 24'hABCDEF; r_start = (c == 5);
      end
      tick();
    end
    r_cvalid = 1'b0; r_start = 1'b0;
    #1 outs("swap2_after_31", 7'b0001010);
    tick();
    outs("clear2", 7'b0011010);
    check("clear2_w", w_weights, bank(24'hF00000));
    tick();
    for (int s = 0; s < 2 * D; s++) begin
      r_svalid = (s % 2 == 1);
      r_start  = (s == 4);
      #1 outs("settle2", {6'b010001, (s == 2 * D - 1)});
      tick();
    end
    r_svalid = 1'b0; r_start = 1'b0;
    #1 outs("idle2", 7'b0101000);
    check("idle2_w", w_weights, bank(24'hF00000));

    // Abort after 7 beats.
    r_start = 1'b1;
    tick();
    r_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      r_cvalid = 1'b1; r_coef = 24'h555555 ^ DW'(i);
      tick();
    end
    r_abort = 1'b1; r_coef = 24'h777777;
    #1 outs("abort_cycle", 7'b1101010);
    tick();
    r_abort = 1'b0; r_cvalid = 1'b0;
    #1 outs("after_abort", 7'b0101000);
    check("after_abort_w", w_weights, bank(24'hF00000));
    tick();
    outs("abort_idle", 7'b0101000);

    // Reset in the middle of SETTLE.
    r_start = 1'b1;
    tick();
    r_start = 1'b0;
    for (int i = 0; i < D; i++) begin
      r_cvalid = 1'b1; r_coef = 24'h000100 + DW'(i);
      tick();
    end
    r_cvalid = 1'b0;
    tick();
    tick();
    check("clear3_w", w_weights, bank(24'h000100));
    r_svalid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    outs("settle3", 7'b0100010);
    r_rst = 1'b1;
    tick();
    outs("rst_mid", 7'b0101000);
    check("rst_mid_w", w_weights, '0);
    r_rst = 1'b0;
    tick();
    outs("post_rst", 7'b0101000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
